// File: rtl/fetch_realigner_q_if.sv
// Fetch-to-decode and ICACHE signal bundle for the instruction realigner.
// The realigner takes the master side; the cache/decode environment takes the slave side.
interface fetch_realigner_q_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        compressed;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;

  modport master (
    input  redirect, redirect_pc, inst_ready, ICACHE_rdata, ICACHE_stall,
    output inst_valid, inst, inst_pc, compressed,
           ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
  );

  modport slave (
    output redirect, redirect_pc, inst_ready, ICACHE_rdata, ICACHE_stall,
    input  inst_valid, inst, inst_pc, compressed,
           ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
  );
endinterface

// File: rtl/fetch_realigner_q.sv
// Instruction realigner: prefetches ICACHE words into a halfword FIFO and hands
// one RV32C/RV32I instruction per cycle to decode at any halfword-aligned PC.
module fetch_realigner_q #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          BYTE_SWAP = 1'b1,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_realigner_q_if.master bus
);
  localparam int unsigned    PW       = $clog2(DEPTH);
  localparam int unsigned    CW       = PW + 1;
  localparam logic [CW-1:0]  FILL_MAX = CW'(DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_PEND} state_t;
  state_t state, state_nxt;

  logic [15:0]   fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [29:0]   fetch_addr;
  logic          skip;
  logic [31:0]   head_pc;
  logic [31:0]   pend_pc;

  logic          busy, ren, complete, push_ok, pop, is32, inst_vld;
  logic [31:0]   d;
  logic [15:0]   h0, h1;
  logic [CW-1:0] n_push, n_pop;
  logic [1:0]    unused_pc_lsb;

  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign busy = (state != S_IDLE);

  // A stalled access keeps ren up regardless of fill level or redirect.
  always_comb begin
    ren = 1'b0;
    if (!rst) ren = busy || ((count <= FILL_MAX) && !bus.redirect);
  end

  assign complete = ren && !bus.ICACHE_stall;
  assign push_ok  = complete && !bus.redirect && (state != S_PEND);
  assign d        = BYTE_SWAP ? byte_rev(bus.ICACHE_rdata) : bus.ICACHE_rdata;

  assign h0       = fifo[rd_ptr];
  assign h1       = fifo[rd_ptr + PW'(1)];
  assign is32     = (h0[1:0] == 2'b11);
  assign inst_vld = !bus.redirect && (state != S_PEND) &&
                    (is32 ? (count >= CW'(2)) : (count != '0));
  assign pop      = inst_vld && bus.inst_ready;
  assign n_push   = push_ok ? (skip ? CW'(1) : CW'(2)) : '0;
  assign n_pop    = pop ? (is32 ? CW'(2) : CW'(1)) : '0;

  assign bus.inst_valid   = inst_vld;
  assign bus.inst         = is32 ? {h1, h0} : {16'h0000, h0};
  assign bus.inst_pc      = head_pc;
  assign bus.compressed   = !is32;
  assign bus.ICACHE_ren   = ren;
  assign bus.ICACHE_wen   = 1'b0;
  assign bus.ICACHE_addr  = fetch_addr;
  assign bus.ICACHE_wdata = 32'h0000_0000;
  assign unused_pc_lsb    = {bus.redirect_pc[0], pend_pc[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ren && bus.ICACHE_stall) state_nxt = S_BUSY;
      S_BUSY:  if (!bus.ICACHE_stall)       state_nxt = S_IDLE;
               else if (bus.redirect)       state_nxt = S_PEND;
      S_PEND:  if (!bus.ICACHE_stall)       state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fetch_addr <= RESET_PC[31:2];
      skip       <= RESET_PC[1];
      head_pc    <= {RESET_PC[31:1], 1'b0};
    end else if (bus.redirect && busy && bus.ICACHE_stall) begin
      // Flush now; the new fetch address waits until the held access retires.
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fetch_addr <= bus.redirect_pc[31:2];
      skip       <= bus.redirect_pc[1];
      head_pc    <= {bus.redirect_pc[31:1], 1'b0};
    end else if (state == S_PEND) begin
      if (complete) begin
        fetch_addr <= pend_pc[31:2];
        skip       <= pend_pc[1];
        head_pc    <= {pend_pc[31:1], 1'b0};
      end
    end else begin
      count  <= count + n_push - n_pop;
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      rd_ptr <= rd_ptr + n_pop[PW-1:0];
      if (complete) begin
        fetch_addr <= fetch_addr + 30'd1;
        skip       <= 1'b0;
      end
      if (pop) head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.redirect && busy && bus.ICACHE_stall) pend_pc <= bus.redirect_pc;
  end

  // Halfword storage; an entry only matters once count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      if (skip) begin
        fifo[wr_ptr] <= d[31:16];
      end else begin
        fifo[wr_ptr]          <= d[15:0];
        fifo[wr_ptr + PW'(1)] <= d[31:16];
      end
    end
  end
endmodule

// File: tb/tb_fetch_realigner_q.sv
// Bench for fetch_realigner_q: a word-addressed memory model feeds the cache port and
// a reference walk of that memory fills the expected-instruction queue.
module tb_fetch_realigner_q;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_realigner_q_if bus_if();

  fetch_realigner_q #(.DEPTH(8), .BYTE_SWAP(1'b1), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] imem [bit [29:0]];
  logic [64:0] exp_q [$];

  function automatic logic [31:0] word_at(input logic [29:0] a);
    if (imem.exists(a)) return imem[a];
    return {a, 2'b11};
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = word_at(pc[31:2]);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic expect_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] h;
    pc = {start[31:1], 1'b0};
    for (int i = 0; i < n; i++) begin
      h = hw_at(pc);
      if (h[1:0] == 2'b11) begin
        exp_q.push_back({hw_at(pc + 32'd2), h, pc, 1'b0});
        pc = pc + 32'd4;
      end else begin
        exp_q.push_back({16'h0000, h, pc, 1'b1});
        pc = pc + 32'd2;
      end
    end
  endtask

  // Cache stores big-endian words; address is stable at the falling edge.
  always @(negedge clk) bus_if.ICACHE_rdata = bswap(word_at(bus_if.ICACHE_addr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus_if.ICACHE_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", bus_if.ICACHE_ren); end
    n_cmp++; if (bus_if.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.inst_valid); end
    n_cmp++; if (bus_if.ICACHE_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus_if.ICACHE_wen); end
    n_cmp++; if (bus_if.ICACHE_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus_if.ICACHE_wdata); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.ICACHE_ren !== 1'b1) begin n_fail++; $display("FAIL post_reset_ren: got %b want 1", bus_if.ICACHE_ren); end
    n_cmp++; if (bus_if.ICACHE_addr !== 30'h0) begin n_fail++; $display("FAIL post_reset_addr: got %h want 0", bus_if.ICACHE_addr); end
    n_cmp++; if (bus_if.inst_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", bus_if.inst_valid); end
  endtask

  task automatic test_aligned();
    logic [64:0] e;
    int first = -1, last = -1, hits = 0;
    expect_stream(32'h0, 2);
    bus_if.inst_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        e = exp_q.pop_front();
        if (first < 0) first = cyc;
        last = cyc; hits++;
        n_cmp++;
        if ({bus_if.inst, bus_if.inst_pc, bus_if.compressed} !== e) begin
          n_fail++;
          $display("FAIL aligned_inst: got %h@%h c=%b want %h@%h c=%b", bus_if.inst, bus_if.inst_pc, bus_if.compressed, e[64:33], e[32:1], e[0]);
        end
      end
      tick();
    end
    bus_if.inst_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL aligned_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (last - first + 1 != hits) begin n_fail++; $display("FAIL aligned_back_to_back: span %0d want %0d", last - first + 1, hits); end
  endtask

  task automatic test_mixed();
    logic [64:0] e;
    imem[30'h0] = 32'h0513_4501;
    imem[30'h1] = 32'h4505_0000;
    expect_stream(32'h0, 3);
    bus_if.redirect_pc = 32'h0;
    bus_if.redirect = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_if.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_forces_invalid: got %b want 0", bus_if.inst_valid); end
    tick();
    bus_if.redirect = 1'b0;
    bus_if.inst_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus_if.inst, bus_if.inst_pc, bus_if.compressed} !== e) begin
          n_fail++;
          $display("FAIL mixed_inst: got %h@%h c=%b want %h@%h c=%b", bus_if.inst, bus_if.inst_pc, bus_if.compressed, e[64:33], e[32:1], e[0]);
        end
      end
      tick();
    end
    bus_if.inst_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mixed_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_unaligned();
    logic [64:0] e;
    imem[30'h40] = 32'h0093_4501;
    imem[30'h41] = 32'h4505_0010;
    expect_stream(32'h102, 2);
    bus_if.redirect_pc = 32'h102;
    bus_if.redirect = 1'b1;
    tick();
    bus_if.redirect = 1'b0;
    bus_if.inst_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus_if.ICACHE_ren, bus_if.ICACHE_addr} !== {1'b1, 30'h40}) begin n_fail++; $display("FAIL unaligned_first_addr: got ren=%b %h want ren=1 40", bus_if.ICACHE_ren, bus_if.ICACHE_addr); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus_if.ICACHE_addr !== 30'h41) begin n_fail++; $display("FAIL unaligned_next_addr: got %h want 41", bus_if.ICACHE_addr); end
    n_cmp++; if (bus_if.inst_valid !== 1'b0) begin n_fail++; $display("FAIL unaligned_half_only: valid %b want 0", bus_if.inst_valid); end
    for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus_if.inst, bus_if.inst_pc, bus_if.compressed} !== e) begin
          n_fail++;
          $display("FAIL unaligned_inst: got %h@%h c=%b want %h@%h c=%b", bus_if.inst, bus_if.inst_pc, bus_if.compressed, e[64:33], e[32:1], e[0]);
        end
      end
      tick();
    end
    bus_if.inst_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL unaligned_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_backpressure();
    logic [64:0] e;
    int first = -1, last = -1, hits = 0;
    expect_stream(32'h400, 12);
    bus_if.redirect_pc = 32'h400;
    bus_if.redirect = 1'b1;
    tick();
    bus_if.redirect = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++; if (bus_if.ICACHE_ren !== 1'b0) begin n_fail++; $display("FAIL bp_ren_drop: got %b want 0", bus_if.ICACHE_ren); end
    n_cmp++; if (bus_if.ICACHE_addr !== 30'h104) begin n_fail++; $display("FAIL bp_fill_addr: got %h want 104", bus_if.ICACHE_addr); end
    n_cmp++; if (bus_if.inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", bus_if.inst_valid); end
    tick();
    bus_if.inst_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        e = exp_q.pop_front();
        if (first < 0) first = cyc;
        last = cyc; hits++;
        n_cmp++;
        if ({bus_if.inst, bus_if.inst_pc, bus_if.compressed} !== e) begin
          n_fail++;
          $display("FAIL bp_inst: got %h@%h c=%b want %h@%h c=%b", bus_if.inst, bus_if.inst_pc, bus_if.compressed, e[64:33], e[32:1], e[0]);
        end
      end
      tick();
    end
    bus_if.inst_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (last - first + 1 != hits) begin n_fail++; $display("FAIL bp_throughput: span %0d want %0d", last - first + 1, hits); end
  endtask

  task automatic test_redirect_stall();
    logic [64:0] e;
    bus_if.redirect_pc = 32'h40;
    bus_if.redirect = 1'b1;
    bus_if.ICACHE_stall = 1'b1;
    tick();
    for (int s = 1; s <= 6; s++) begin
      bus_if.redirect = (s == 2);
      if (s == 2) bus_if.redirect_pc = 32'h200;
      bus_if.ICACHE_stall = (s <= 5);
      @(negedge clk);
      n_cmp++;
      if ({bus_if.ICACHE_ren, bus_if.ICACHE_addr, bus_if.inst_valid} !== {1'b1, 30'h10, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold_c%0d: got ren=%b addr=%h valid=%b want ren=1 addr=10 valid=0", s, bus_if.ICACHE_ren, bus_if.ICACHE_addr, bus_if.inst_valid);
      end
      tick();
    end
    bus_if.redirect = 1'b0;
    bus_if.ICACHE_stall = 1'b0;
    expect_stream(32'h200, 3);
    @(negedge clk);
    n_cmp++; if ({bus_if.ICACHE_ren, bus_if.ICACHE_addr, bus_if.inst_valid} !== {1'b1, 30'h80, 1'b0}) begin n_fail++; $display("FAIL stall_restart: got ren=%b addr=%h valid=%b want ren=1 addr=80 valid=0", bus_if.ICACHE_ren, bus_if.ICACHE_addr, bus_if.inst_valid); end
    bus_if.inst_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus_if.inst, bus_if.inst_pc, bus_if.compressed} !== e) begin
          n_fail++;
          $display("FAIL stall_inst: got %h@%h c=%b want %h@%h c=%b", bus_if.inst, bus_if.inst_pc, bus_if.compressed, e[64:33], e[32:1], e[0]);
        end
      end
      tick();
    end
    bus_if.inst_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_stall();
    logic [64:0] e;
    bus_if.redirect_pc = 32'h300;
    bus_if.redirect = 1'b1;
    tick();
    bus_if.redirect = 1'b0;
    repeat (3) tick();
    bus_if.ICACHE_stall = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if ({bus_if.inst_valid, bus_if.ICACHE_ren, bus_if.ICACHE_addr} !== {1'b1, 1'b1, 30'hC3}) begin n_fail++; $display("FAIL pre_reset_state: got valid=%b ren=%b addr=%h want 1 1 c3", bus_if.inst_valid, bus_if.ICACHE_ren, bus_if.ICACHE_addr); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_if.inst_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", bus_if.inst_valid); end
    n_cmp++; if (bus_if.ICACHE_ren !== 1'b0) begin n_fail++; $display("FAIL async_reset_ren: got %b want 0", bus_if.ICACHE_ren); end
    n_cmp++; if (bus_if.ICACHE_addr !== 30'h0) begin n_fail++; $display("FAIL async_reset_addr: got %h want 0", bus_if.ICACHE_addr); end
    tick();
    rst = 1'b0;
    bus_if.ICACHE_stall = 1'b0;
    bus_if.inst_ready = 1'b1;
    expect_stream(32'h0, 3);
    @(negedge clk);
    n_cmp++; if ({bus_if.ICACHE_ren, bus_if.ICACHE_addr} !== {1'b1, 30'h0}) begin n_fail++; $display("FAIL restart_after_reset: got ren=%b addr=%h want ren=1 addr=0", bus_if.ICACHE_ren, bus_if.ICACHE_addr); end
    for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus_if.inst, bus_if.inst_pc, bus_if.compressed} !== e) begin
          n_fail++;
          $display("FAIL reset_restart_inst: got %h@%h c=%b want %h@%h c=%b", bus_if.inst, bus_if.inst_pc, bus_if.compressed, e[64:33], e[32:1], e[0]);
        end
      end
      tick();
    end
    bus_if.inst_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reset_restart_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    bus_if.redirect     = 1'b0;
    bus_if.redirect_pc  = 32'h0;
    bus_if.inst_ready   = 1'b0;
    bus_if.ICACHE_stall = 1'b0;
    imem[30'h0] = 32'h0000_0013;
    imem[30'h1] = 32'h0010_0093;
    test_reset();
    test_aligned();
    test_mixed();
    test_unaligned();
    test_backpressure();
    test_redirect_stall();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
